// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: state encoding and prescaler sizing.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Prescaler width: clog2(div), never narrower than one bit.
  function automatic int prescaler_width(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Clock-enable prescaler: counts 0..DIV-1 while enabled and emits a one-cycle tick at DIV-1.
module tick_gen
  import timer_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = prescaler_width(DIV);
  localparam logic [PW-1:0] MAX = PW'(DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == MAX);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + PW'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/stop/pause control, prescaled decrement and a done pulse.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int N   = 8,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         start,
  input  logic         stop,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         paused,
  output logic         expired,
  output logic         done
);

  state_e       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic         done_q, done_d;
  logic         tick, pre_clr, pre_en, start_eff;

  // stop outranks start, and load outranks both.
  assign start_eff = start && !stop;
  assign pre_clr   = load || (state_q == IDLE && start_eff);
  // A stop on what would be a tick edge freezes the prescaler, so the tick is suppressed.
  assign pre_en    = (state_q == RUN) && !load && !stop;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (load) begin
      count_d = load_val;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (start_eff) state_d = (count_q == '0) ? DONE : RUN;
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (tick && count_q != '0) begin
            count_d = count_q - N'(1);
            if (count_q == N'(1)) state_d = DONE;
          end
        end
        PAUSE: if (start_eff) state_d = RUN;
        DONE:  state_d = DONE;
      endcase
    end
    done_d = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count   = count_q;
  assign busy    = (state_q == RUN);
  assign paused  = (state_q == PAUSE);
  assign expired = (state_q == DONE);
  assign done    = done_q;

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable N-bit down-counter with start/pause/stop control and an internal clock-enable prescaler. It is the decrementing counterpart to the team's up-counter. It sits beside the free-running counters in the timer/display path. Software-style control pulses (load, start, stop) come from the button/FSM layer, and the block reports the current count plus a one-cycle `done` pulse when it reaches zero.

## Interface
- `N`, default 8: count width in bits.
- `DIV`, default 4: prescaler ratio, clock cycles per decrement. Legal range is DIV ≥ 1.
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `load`  in  1: load `load_val` into the count (level sampled each edge).
- `load_val`  in  N: value to load.
- `start`  in  1: begin or resume counting.
- `stop`  in  1: pause counting.
- `count`  out  N: current count value.
- `busy`  out  1: high while in RUN.
- `paused`  out  1: high while in PAUSE.
- `expired`  out  1: high while in DONE.
- `done`  out  1: one-cycle pulse on entry to DONE.

## Operation
- States are IDLE, RUN, PAUSE and DONE. Reset puts the block in IDLE.
- Control priority on each edge is rst > load > stop > start.
- `load` in any state:
  - count ← load_val, prescaler ← 0, state → IDLE.
  - A simultaneous start or stop is ignored.
- `start` depends on state:
  - In IDLE with count ≠ 0: state → RUN, prescaler ← 0.
  - In IDLE with count = 0: state → DONE directly, and `done` pulses.
  - In PAUSE: state → RUN, prescaler keeps its held value (resumes mid-period).
  - In RUN or DONE: ignored. Leaving DONE requires `load`.
- `stop` in RUN: state → PAUSE, count and prescaler hold. In other states it is ignored.
- Prescaler behaviour:
  - Counts 0…DIV-1 only in RUN.
  - Internal tick = RUN && prescaler == DIV-1. The prescaler wraps to 0 on the tick.
  - With DIV = 1, tick is high every RUN cycle.
- On a tick:
  - count ← count − 1.
  - If count was 1, state → DONE.
  - count never wraps below 0.
- `stop` arriving on a tick edge has priority: no decrement, state → PAUSE.
- Outputs are decoded from state: busy = RUN, paused = PAUSE, expired = DONE.
- `done` is high exactly in the first cycle that state equals DONE.
- All outputs are 0 after reset, and count = 0.

## Timing
- `start` sampled at edge k from IDLE: busy = 1 after edge k.
  - First decrement happens at edge k+DIV.
  - count reaches 0, and expired = done = 1, after edge k + load_val·DIV.
- `done` falls after one cycle. expired stays high until `load` or `rst`.
- `load` takes effect at the same edge: count = load_val on the next cycle.
- Pause/resume: total RUN cycles from start to expiry are always load_val·DIV, independent of how many pauses occur.
- `rst` asserted mid-RUN clears everything immediately, without waiting for a clock edge.

## Structure
- Shared package `timer_pkg` holds:
  - the state encoding constants (IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3);
  - a function giving the prescaler width, clog2(DIV) with a minimum of 1.
- Sub-module `tick_gen`, parameterised by DIV. Its ports are clk, rst, clr, en, tick. It contains the prescaler and produces the one-cycle tick.
- The top level holds the state register, the count register and output decode.

## Test plan
- Reset: assert rst mid-cycle → count = 0, busy/paused/expired/done = 0 immediately.
- Basic countdown, N = 8, DIV = 4: load 5, start → decrements at +4, +8, …; expired and done = 1 exactly 20 cycles after start; done lasts 1 cycle.
- Pause/resume: load 3, start, stop after 6 cycles (count = 2, prescaler = 2), hold 10 cycles, start → expiry 6 RUN cycles later, 12 RUN cycles total.
- Zero and priority:
  - load 0 then start → DONE next cycle with done pulse.
  - load + start in the same cycle → IDLE, count = load_val.
  - stop on a tick edge → no decrement.
- DIV = 1 variant: load 255, start → count decrements every cycle; expired after exactly 255 cycles; count never wraps to 255.
- Ignored controls: start while RUN and start while DONE leave state and prescaler unchanged; load from DONE → IDLE with expired = 0.
